// File: rtl/enc_16to4_seq.sv
// Sequential 16-to-4 priority encoder: captures a multi-hot request vector and
// drains it one index per handshake. Define ENC_LSB_PRIORITY_EN for ascending order.
module enc_16to4_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic [3:0]  out,
  output logic        valid,
  output logic        last,
  output logic        busy,
  output logic        zero
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t      state;
  logic [15:0] pending;
  logic        handshake;
  logic        one_left;

  function automatic logic [3:0] encode(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
`ifdef ENC_LSB_PRIORITY_EN
    // scan downward so the lowest set bit is the last one written
    for (int unsigned i = 0; i < 16; i++)
      if (v[15-i]) idx = 4'(15 - i);
`else
    for (int unsigned i = 0; i < 16; i++)
      if (v[i]) idx = 4'(i);
`endif
    return idx;
  endfunction

  always_comb begin
    out       = encode(pending);
    busy      = (state == DRAIN);
    valid     = en & busy;
    one_left  = (pending != '0) && ((pending & (pending - 16'd1)) == '0);
    last      = valid & one_left;
    handshake = valid & out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      zero    <= 1'b0;
    end else begin
      zero <= 1'b0;
      case (state)
        IDLE: begin
          if (en && load) begin
            if (req != '0) begin
              pending <= req;
              state   <= DRAIN;
            end else begin
              zero <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            pending <= pending & ~(16'h0001 << out);
            if (one_left) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/enc_16to4_seq.md
# enc_16to4_seq

Sequential 16-to-4 priority encoder: the encode-side counterpart to the team's 4-to-16 decoder. It captures a 16-bit multi-hot request vector and drains it one index per handshake, emitting the 4-bit binary index of each set bit in priority order. It sits upstream of `dec_4to16`-style one-hot consumers: the index it emits re-expands there into a single select line.

## Interface
Parameters: none (width fixed at 16→4).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when 0, the block freezes: no load, no handshake, valid forced 0
- load  in  1  capture `req` into the pending register (honoured only in IDLE with en=1)
- req  in  16  request vector; bit i requests index i
- out_ready  in  1  consumer accepts the current index
- out  out  4  binary index of the current highest-priority pending bit
- valid  out  1  `out` is meaningful
- last  out  1  asserted with valid when exactly one pending bit remains
- busy  out  1  FSM in DRAIN
- zero  out  1  one-cycle pulse: a load captured an all-zero vector

## Operation
- State: `pending[15:0]`, FSM {IDLE, DRAIN}, `zero` flag register.
- IDLE:
  - If en & load & req≠0: pending←req, go to DRAIN.
  - If en & load & req==0: pending stays 0, zero←1 for one cycle, remain in IDLE.
- DRAIN:
  - `out` is the encode of the winning pending bit; valid=en.
  - Handshake is valid & out_ready at a rising edge. On handshake: clear the winning bit in pending.
  - If the cleared bit was the last one, go to IDLE in the same edge.
- Priority: highest index wins by default (bit 15 first); see Configuration.
- `last` = valid & (popcount(pending)==1).
- Outputs are decoded from registers only; there is no combinational path from req or load to outputs.
- `load` in DRAIN is ignored, including when it coincides with the final handshake. A new load must be presented in IDLE.
- When en=0:
  - State and pending hold.
  - valid=0 and last=0; out holds its encoded value.
  - busy still reflects state.
  - zero still clears after its one cycle.
- `req` is sampled only at a load edge; changes at other times have no effect.

## Timing
- Reset (asynchronous, immediate):
  - pending=0, FSM=IDLE.
  - out=4'd0, valid=0, last=0, busy=0, zero=0.
- Reset asserted mid-drain aborts the vector; no further indices are emitted.
- Load latency: a load at edge N gives busy=1, valid=1 and the first index, visible after edge N.
- Throughput: one index per cycle while out_ready=1 and en=1. A vector with k set bits drains in k cycles.
- Final handshake at edge M: after M, busy=0 and valid=0. The earliest new load is accepted at edge M+1.
- Zero pulse: load of 0 at edge N gives zero=1 after edge N, cleared after edge N+1. busy stays 0.
- out_ready held low: out, valid and last remain stable indefinitely.

## Configuration
- `ENC_LSB_PRIORITY_EN`:
  - Defined: lowest index wins (bit 0 first); drain order is ascending.
  - Undefined (default): highest index wins (bit 15 first); drain order is descending.
- `last`, `zero` and the handshake rules are identical in both builds.

## Test plan
- Reset mid-drain: load 16'hFFFF, accept 3 indices, assert rst asynchronously between edges → all outputs 0 immediately; after release, busy=0.
- Single bit: load 16'h0100 with out_ready=1 → out=8, valid=1, last=1 for one cycle; busy=0 on the next cycle.
- Multi-hot drain: load 16'h8421, out_ready=1 →
  - Default build: out 15,10,5,0 on consecutive cycles, last=1 only with 0.
  - With `ENC_LSB_PRIORITY_EN`: out 0,5,10,15.
- Backpressure and enable: load 16'h0003, hold out_ready=0 for 4 cycles → out=1 stable. Then en=0 for 2 cycles with out_ready=1 → valid=0, pending unchanged. Then en=1 → out 1, then 0.
- Zero and ignored load:
  - Load 16'h0000 → zero pulses for one cycle, busy stays 0.
  - Then load 16'h0010 and, during its drain, assert load with req=16'hFFFF → only index 4 is emitted; the FFFF vector is ignored.
- Exhaustive single-hot: for i=0..15, load 1<<i → out=i, last=1. Feed out to a `dec_4to16` with en=1 → that decoder's output i is high.
